seg7_scan_reader: RTL

//  Watches a time-multiplexed, active-low 7-segment display bus (anodes + segments) as it leaves the board.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg_pattern_encoder.sv | 31 +++
 rtl/seg7_scan_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern and code constants for the 7-segment scan reader
// Patterns are active-low, bit0 = segment a .. bit6 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg_pattern_encoder.sv
// rtl/seg_pattern_encoder.sv - exact-match 7-segment pattern to 4-bit code encoder
// Ports:
//   seg_i  : active-low segment pattern, bit0 = a .. bit6 = g
//   code_o : 4'h0..4'h9 digits, CODE_E for 'E', CODE_BLANK for all-off, CODE_BAD otherwise
module seg_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_BAD;
        case (seg_i)
            SEG_0:     code_o = 4'h0;
            SEG_1:     code_o = 4'h1;
            SEG_2:     code_o = 4'h2;
            SEG_3:     code_o = 4'h3;
            SEG_4:     code_o = 4'h4;
            SEG_5:     code_o = 4'h5;
            SEG_6:     code_o = 4'h6;
            SEG_7:     code_o = 4'h7;
            SEG_8:     code_o = 4'h8;
            SEG_9:     code_o = 4'h9;
            SEG_E:     code_o = CODE_E;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers digit codes from a multiplexed active-low 7-segment bus
// Ports:
//   clk100_i      : system clock
//   rst_i         : asynchronous reset, active-high
//   an_i          : anode enables, active-low, bit n = digit n
//   seg_i         : segments, active-low, bit0 = a .. bit6 = g
//   digits_o      : last complete frame, digit n at [4n+3:4n]
//   frame_valid_o : one-cycle pulse when digits_o / frame_err_o update
//   frame_err_o   : last frame had a bad pattern or a multi-anode capture
//   timeout_o     : no frame completed for TIMEOUT_CYCLES
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                clk100_i,
    input  logic                rst_i,
    input  logic [DIGITS-1:0]   an_i,
    input  logic [6:0]          seg_i,
    output logic [4*DIGITS-1:0] digits_o,
    output logic                frame_valid_o,
    output logic                frame_err_o,
    output logic                timeout_o
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CYCLES - 1);

    logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
    logic [SW-1:0]       stab_cnt_q, stab_cnt_d;
    logic                armed_q, armed_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] frame_buf_q, frame_buf_d;
    logic                err_acc_q, err_acc_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                timeout_q, timeout_d;

    logic                changed, capture, blank, onehot, multi;
    logic                cap_single, cur_err, close;
    logic [DIGITS-1:0]   an_low, seen_next;
    logic [IW-1:0]       idx;
    logic [3:0]          code;

    // Captures use the stable (previous) value, which by definition has held
    // for STABLE_CYCLES when the capture fires.
    seg_pattern_encoder u_enc (
        .seg_i  (seg_prev_q),
        .code_o (code)
    );

    always_comb begin
        changed    = ({an_s2_q, seg_s2_q} != {an_prev_q, seg_prev_q});
        capture    = armed_q && (stab_cnt_q == STAB_MAX);

        an_low     = ~an_prev_q;
        blank      = (an_low == '0);
        onehot     = !blank && ((an_low & (an_low - 1'b1)) == '0);
        multi      = !blank && !onehot;

        // Lowest set index; only meaningful once onehot is known true.
        idx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (an_low[i]) idx = IW'(i);
        end

        cap_single = capture && onehot;
        cur_err    = (capture && multi) || (cap_single && (code == CODE_BAD));
        seen_next  = seen_q | (cap_single ? an_low : '0);
        close      = cap_single && (&seen_next);

        stab_cnt_d = changed ? '0 : ((stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1);
        armed_d    = changed ? 1'b1 : (capture ? 1'b0 : armed_q);

        frame_buf_d = frame_buf_q;
        if (cap_single) frame_buf_d[4*int'(idx) +: 4] = code;

        digits_d      = digits_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = close;
        seen_d        = seen_next;
        err_acc_d     = err_acc_q | cur_err;
        tmo_cnt_d     = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        timeout_d     = timeout_q | (tmo_cnt_q == TMO_FIRE);

        // A close overrides a simultaneous timeout expiry.
        if (close) begin
            digits_d    = frame_buf_d;
            frame_err_d = err_acc_q | cur_err;
            seen_d      = '0;
            err_acc_d   = 1'b0;
            tmo_cnt_d   = '0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            an_s1_q       <= '0;
            an_s2_q       <= '0;
            an_prev_q     <= '0;
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            seg_prev_q    <= '0;
            stab_cnt_q    <= '0;
            armed_q       <= 1'b0;
            seen_q        <= '0;
            frame_buf_q   <= '1;
            err_acc_q     <= 1'b0;
            digits_q      <= '1;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
        end else begin
            an_s1_q       <= an_i;
            an_s2_q       <= an_s1_q;
            an_prev_q     <= an_s2_q;
            seg_s1_q      <= seg_i;
            seg_s2_q      <= seg_s1_q;
            seg_prev_q    <= seg_s2_q;
            stab_cnt_q    <= stab_cnt_d;
            armed_q       <= armed_d;
            seen_q        <= seen_d;
            frame_buf_q   <= frame_buf_d;
            err_acc_q     <= err_acc_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign digits_o      = digits_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_err_o   = frame_err_q;
    assign timeout_o     = timeout_q;

endmodule
